// File: rtl/poly_clip_sched.sv
// Sequences one shared single-edge clip unit through TOP/BOTTOM/LEFT/RIGHT polygon clipping.
// Latency: load + 4 passes of (n edges x clip latency + 1) + drain; next edge issues the cycle after a result.
// Backpressure: in_ready low while busy; edge and output beats hold stable until their ready is seen.
module poly_clip_sched #(
  parameter int COORD_W   = 16,
  parameter int MAX_VERTS = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*COORD_W-1:0] in_vert,
  input  logic                 in_last,
  output logic                 edge_valid,
  input  logic                 edge_ready,
  output logic [2*COORD_W-1:0] edge_s,
  output logic [2*COORD_W-1:0] edge_p,
  output logic [1:0]           edge_side,
  input  logic                 res_valid,
  input  logic [1:0]           res_nvert,
  input  logic [2*COORD_W-1:0] res_v0,
  input  logic [2*COORD_W-1:0] res_v1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*COORD_W-1:0] out_vert,
  output logic                 out_last,
  output logic                 out_null,
  output logic                 out_ovf
);

  localparam int VW    = 2 * COORD_W;
  localparam int IDX_W = (MAX_VERTS > 1) ? $clog2(MAX_VERTS) : 1;
  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_VERTS);
  localparam logic [CNT_W-1:0] MINV = CNT_W'(3);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_DRAIN} state_t;

  state_t            state_q;
  logic              bank_q;      // bank holding the source polygon of the current pass
  logic [1:0]        side_q;
  logic [CNT_W-1:0]  n_q;         // source vertex count (load count while loading)
  logic [CNT_W-1:0]  dcnt_q;      // destination vertex count for the current pass
  logic [CNT_W-1:0]  e_q;         // current edge index
  logic [CNT_W-1:0]  rd_q;        // drain read index
  logic              ovf_q;
  logic              in_ready_q;
  logic              edge_valid_q;
  logic [VW-1:0]     edge_s_q, edge_p_q;
  logic              out_valid_q, out_last_q, out_null_q, out_ovf_q;
  logic [VW-1:0]     out_vert_q;
  logic [VW-1:0]     mem_q [2][MAX_VERTS];

  logic              ld_hs, ld_keep, res_hs, keep0, keep1, res_drop, src_last, nb, drain_last_d;
  logic [CNT_W-1:0]  ld_n_d, res_cnt_d, nxt_e_d, nxt_p_d, drain_nxt_d;
  logic              wr0_en_d, wr0_bank_d, wr1_en_d;
  logic [IDX_W-1:0]  wr0_idx_d, wr1_idx_d;
  logic [VW-1:0]     wr0_dat_d;

  assign in_ready   = in_ready_q;
  assign edge_valid = edge_valid_q;
  assign edge_s     = edge_s_q;
  assign edge_p     = edge_p_q;
  assign edge_side  = side_q;
  assign out_valid  = out_valid_q;
  assign out_vert   = out_vert_q;
  assign out_last   = out_last_q;
  assign out_null   = out_null_q;
  assign out_ovf    = out_ovf_q;

  // Derived counts: load accept, how many clip results fit, next edge and drain indices.
  always_comb begin
    ld_hs        = in_valid & in_ready_q;
    ld_keep      = n_q < MAXV;
    ld_n_d       = n_q + CNT_W'(ld_keep);
    res_hs       = res_valid & (state_q == S_WAIT);
    keep0        = (res_nvert != 2'd0) && (dcnt_q < MAXV);
    keep1        = (res_nvert == 2'd2) && ((dcnt_q + CNT_W'(1)) < MAXV);
    res_drop     = ((res_nvert != 2'd0) && !keep0) || ((res_nvert == 2'd2) && !keep1);
    res_cnt_d    = dcnt_q + CNT_W'(keep0) + CNT_W'(keep1);
    src_last     = (e_q == (n_q - CNT_W'(1)));
    nxt_e_d      = e_q + CNT_W'(1);
    nxt_p_d      = ((e_q + CNT_W'(2)) == n_q) ? '0 : (e_q + CNT_W'(2));
    nb           = ~bank_q;
    drain_nxt_d  = rd_q + CNT_W'(1);
    drain_last_d = ((rd_q + CNT_W'(2)) == n_q);
  end

  // Vertex buffer write ports: port 0 takes loads or the first result, port 1 the second result.
  always_comb begin
    wr0_en_d   = 1'b0;
    wr0_bank_d = 1'b0;
    wr0_idx_d  = '0;
    wr0_dat_d  = '0;
    if (ld_hs && ld_keep) begin
      wr0_en_d  = 1'b1;
      wr0_idx_d = IDX_W'(n_q);
      wr0_dat_d = in_vert;
    end else if (res_hs && keep0) begin
      wr0_en_d   = 1'b1;
      wr0_bank_d = nb;
      wr0_idx_d  = IDX_W'(dcnt_q);
      wr0_dat_d  = res_v0;
    end
    wr1_en_d  = res_hs && keep1;
    wr1_idx_d = IDX_W'(dcnt_q + CNT_W'(1));
  end

  // Ping-pong vertex storage; contents are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (wr0_en_d) mem_q[wr0_bank_d][wr0_idx_d] <= wr0_dat_d;
    if (wr1_en_d) mem_q[nb][wr1_idx_d] <= res_v1;
  end

  // Sequencer: load, per-side edge issue/collect, bank swap, drain; all outputs registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      bank_q       <= 1'b0;
      side_q       <= 2'd0;
      n_q          <= '0;
      dcnt_q       <= '0;
      e_q          <= '0;
      rd_q         <= '0;
      ovf_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      edge_valid_q <= 1'b0;
      edge_s_q     <= '0;
      edge_p_q     <= '0;
      out_valid_q  <= 1'b0;
      out_vert_q   <= '0;
      out_last_q   <= 1'b0;
      out_null_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (ld_hs) begin
            n_q <= ld_n_d;
            if (!ld_keep) ovf_q <= 1'b1;
            if (in_last) begin
              in_ready_q <= 1'b0;
              e_q        <= '0;
              side_q     <= 2'd0;
              if (ld_n_d < MINV) begin
                state_q     <= S_DRAIN;
                out_valid_q <= 1'b1;
                out_vert_q  <= '0;
                out_last_q  <= 1'b1;
                out_null_q  <= 1'b1;
                out_ovf_q   <= ovf_q;
              end else begin
                state_q      <= S_ISSUE;
                edge_valid_q <= 1'b1;
                edge_s_q     <= mem_q[1'b0][IDX_W'(0)];
                edge_p_q     <= mem_q[1'b0][IDX_W'(1)];
              end
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_ISSUE: begin
          if (edge_ready) begin
            edge_valid_q <= 1'b0;
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (res_valid) begin
            dcnt_q <= res_cnt_d;
            if (res_drop) ovf_q <= 1'b1;
            if (src_last) begin
              state_q <= S_NEXT;
            end else begin
              e_q          <= nxt_e_d;
              state_q      <= S_ISSUE;
              edge_valid_q <= 1'b1;
              edge_s_q     <= mem_q[bank_q][IDX_W'(nxt_e_d)];
              edge_p_q     <= mem_q[bank_q][IDX_W'(nxt_p_d)];
            end
          end
        end
        S_NEXT: begin
          bank_q <= nb;
          n_q    <= dcnt_q;
          dcnt_q <= '0;
          e_q    <= '0;
          if (dcnt_q < MINV) begin
            state_q     <= S_DRAIN;
            out_valid_q <= 1'b1;
            out_vert_q  <= '0;
            out_last_q  <= 1'b1;
            out_null_q  <= 1'b1;
            out_ovf_q   <= ovf_q;
          end else if (side_q == 2'd3) begin
            state_q     <= S_DRAIN;
            rd_q        <= '0;
            out_valid_q <= 1'b1;
            out_vert_q  <= mem_q[nb][IDX_W'(0)];
            out_last_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
          end else begin
            side_q       <= side_q + 2'd1;
            state_q      <= S_ISSUE;
            edge_valid_q <= 1'b1;
            edge_s_q     <= mem_q[nb][IDX_W'(0)];
            edge_p_q     <= mem_q[nb][IDX_W'(1)];
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= S_IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_vert_q  <= '0;
              out_last_q  <= 1'b0;
              out_null_q  <= 1'b0;
              out_ovf_q   <= 1'b0;
              n_q         <= '0;
              dcnt_q      <= '0;
              e_q         <= '0;
              rd_q        <= '0;
              ovf_q       <= 1'b0;
              bank_q      <= 1'b0;
              side_q      <= 2'd0;
            end else begin
              rd_q       <= drain_nxt_d;
              out_vert_q <= mem_q[bank_q][IDX_W'(drain_nxt_d)];
              out_last_q <= drain_last_d;
              out_ovf_q  <= drain_last_d & ovf_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_clip_sched.sv
// Randomized scoreboard bench for poly_clip_sched with a behavioural clip unit and reference model.
module tb_poly_clip_sched;
  localparam int MV = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_vert;
  logic        edge_valid, edge_ready;
  logic [31:0] edge_s, edge_p;
  logic [1:0]  edge_side;
  logic        res_valid;
  logic [1:0]  res_nvert;
  logic [31:0] res_v0, res_v1;
  logic        out_valid, out_ready, out_last, out_null, out_ovf;
  logic [31:0] out_vert;

  poly_clip_sched #(.COORD_W(16), .MAX_VERTS(MV), .CNT_W(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vert(in_vert), .in_last(in_last),
    .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_s(edge_s), .edge_p(edge_p),
    .edge_side(edge_side),
    .res_valid(res_valid), .res_nvert(res_nvert), .res_v0(res_v0), .res_v1(res_v1),
    .out_valid(out_valid), .out_ready(out_ready), .out_vert(out_vert), .out_last(out_last),
    .out_null(out_null), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] side; logic [31:0] s; logic [31:0] p; } edge_t;
  typedef struct packed { logic [31:0] v; logic last; logic nul; logic ovf; } beat_t;

  edge_t exp_edges[$];
  beat_t exp_beats[$];
  int n_checks = 0;
  int n_pass   = 0;
  int mode = 0;         // clip unit behaviour: 0 pass, 1 kill on TOP, 2 double, 3 hashed
  int lat_min = 0, lat_max = 2;
  int stall_req = 0;
  int oready_mode = 0;  // 0 always ready, 1 toggle, 2 random
  int eready_rand = 0;
  bit saw_left = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
  endtask

  // Behaviour of the external clip unit, shared by the responder and the reference model.
  function automatic void clipfn(input int md, input logic [1:0] side, input logic [31:0] s,
                                 input logic [31:0] p, output logic [1:0] nv,
                                 output logic [31:0] v0, output logic [31:0] v1);
    logic [31:0] h;
    int k;
    nv = 2'd1; v0 = p; v1 = 32'h0;
    case (md)
      1: if (side == 2'd0) nv = 2'd0;
      2: begin nv = 2'd2; v0 = s ^ 32'h0101_0000; v1 = p; end
      3: begin
        h  = s ^ (p << 3) ^ ({30'd0, side} * 32'h9E37);
        k  = int'(h % 32'd7);
        nv = (k == 0) ? 2'd0 : (k <= 2) ? 2'd2 : 2'd1;
        v0 = p ^ {14'd0, side, 16'd0};
        v1 = s + p;
      end
      default: ;
    endcase
  endfunction

  // Reference: whole-polygon Sutherland-Hodgman sequencing with list semantics.
  task automatic model(input logic [31:0] vin[$]);
    logic [31:0] src[$];
    logic [31:0] dst[$];
    logic [1:0]  nv;
    logic [31:0] v0, v1;
    edge_t ed;
    beat_t b;
    bit ovf, nul;
    int sz;
    ovf = vin.size() > MV;
    for (int i = 0; i < vin.size() && i < MV; i++) src.push_back(vin[i]);
    nul = src.size() < 3;
    for (int sd = 0; sd < 4 && !nul; sd++) begin
      dst = {};
      sz = src.size();
      for (int e = 0; e < sz; e++) begin
        ed.side = 2'(sd); ed.s = src[e]; ed.p = src[(e + 1) % sz];
        exp_edges.push_back(ed);
        clipfn(mode, ed.side, ed.s, ed.p, nv, v0, v1);
        if (nv >= 2'd1) begin if (dst.size() < MV) dst.push_back(v0); else ovf = 1'b1; end
        if (nv == 2'd2) begin if (dst.size() < MV) dst.push_back(v1); else ovf = 1'b1; end
      end
      src = dst;
      nul = src.size() < 3;
    end
    if (nul) begin
      b.v = 32'h0; b.last = 1'b1; b.nul = 1'b1; b.ovf = ovf;
      exp_beats.push_back(b);
    end else begin
      sz = src.size();
      for (int i = 0; i < sz; i++) begin
        b.v = src[i]; b.last = (i == sz - 1); b.nul = 1'b0; b.ovf = (i == sz - 1) && ovf;
        exp_beats.push_back(b);
      end
    end
  endtask

  // Clip unit: accepts edges, checks them against the model, returns results after a latency.
  initial begin
    logic pend, hold;
    int cnt;
    logic [1:0] rnv;
    logic [31:0] r0, r1;
    edge_t held, ex;
    edge_ready = 1'b0; res_valid = 1'b0; res_nvert = 2'd0; res_v0 = '0; res_v1 = '0;
    pend = 1'b0; hold = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (n_rst !== 1'b1) begin pend = 1'b0; hold = 1'b0; edge_ready = 1'b0; continue; end
      if (hold) begin
        chk("edge_hold_vld", edge_valid, 1'b1);
        chk("edge_hold_s", edge_s, held.s);
        chk("edge_hold_p", edge_p, held.p);
        chk("edge_hold_side", edge_side, held.side);
      end
      if (pend) begin
        if (cnt == 0) begin
          res_valid = 1'b1; res_nvert = rnv; res_v0 = r0; res_v1 = r1; pend = 1'b0;
        end else cnt--;
      end else if (!edge_valid && $urandom_range(0, 19) == 0) begin
        res_valid = 1'b1; res_nvert = 2'd2; res_v0 = $urandom; res_v1 = $urandom;
      end
      if (stall_req > 0 && edge_valid) begin
        edge_ready = 1'b0; stall_req--;
      end else edge_ready = (eready_rand != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (edge_valid && edge_ready) begin
        hold = 1'b0;
        if (exp_edges.size() == 0) begin
          n_checks++;
          $display("FAIL edge_unexpected actual=side%0d s=%h p=%h required=none t=%0t",
                   edge_side, edge_s, edge_p, $time);
        end else begin
          ex = exp_edges.pop_front();
          chk("edge_side", edge_side, ex.side);
          chk("edge_s", edge_s, ex.s);
          chk("edge_p", edge_p, ex.p);
        end
        if (edge_side == 2'd2) saw_left = 1'b1;
        clipfn(mode, edge_side, edge_s, edge_p, rnv, r0, r1);
        pend = 1'b1;
        cnt = $urandom_range(lat_min, lat_max);
      end else begin
        hold = edge_valid;
        held.side = edge_side; held.s = edge_s; held.p = edge_p;
      end
    end
  end

  // Output monitor: drives out_ready, checks hold behaviour and pops the expected beats.
  initial begin
    logic hold, tog;
    beat_t held, ex;
    out_ready = 1'b0; hold = 1'b0; tog = 1'b0;
    forever begin
      @(negedge clk);
      if (n_rst !== 1'b1) begin hold = 1'b0; out_ready = 1'b0; continue; end
      if (hold) begin
        chk("out_hold_vld", out_valid, 1'b1);
        chk("out_hold_beat", {out_vert, out_last, out_null, out_ovf}, held);
      end
      case (oready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = tog; tog = ~tog; end
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (out_valid && out_ready) begin
        hold = 1'b0;
        if (exp_beats.size() == 0) begin
          n_checks++;
          $display("FAIL out_unexpected actual=%h required=none t=%0t", out_vert, $time);
        end else begin
          ex = exp_beats.pop_front();
          chk("out_vert", out_vert, ex.v);
          chk("out_last", out_last, ex.last);
          chk("out_null", out_null, ex.nul);
          chk("out_ovf", out_ovf, ex.ovf);
        end
      end else begin
        hold = out_valid;
        held = {out_vert, out_last, out_null, out_ovf};
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_edge_valid"}, edge_valid, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_out_null"}, out_null, 1'b0);
    chk({tag, "_out_ovf"}, out_ovf, 1'b0);
    chk({tag, "_edge_s"}, edge_s, 32'h0);
    chk({tag, "_edge_p"}, edge_p, 32'h0);
    chk({tag, "_edge_side"}, edge_side, 2'd0);
    chk({tag, "_out_vert"}, out_vert, 32'h0);
  endtask

  task automatic load_poly(input logic [31:0] v[$], input bit gaps);
    int i, guard;
    model(v);
    i = 0; guard = 0;
    while (i < v.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin in_valid = 1'b0; in_last = 1'b0; continue; end
      in_valid = 1'b1; in_vert = v[i]; in_last = (i == v.size() - 1);
      if (in_ready) i++;
    end
    chk("load_done", (i == v.size()), 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while ((exp_beats.size() != 0 || exp_edges.size() != 0) && t < 3000) begin
      @(negedge clk); t++;
    end
    chk({tag, "_complete"}, (t < 3000), 1'b1);
    exp_beats.delete(); exp_edges.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic send_poly(input string tag, input logic [31:0] v[$], input bit gaps);
    load_poly(v, gaps);
    wait_done(tag);
  endtask

  initial begin
    logic [31:0] tri_q[$];
    logic [31:0] q[$];
    int t;
    in_valid = 1'b0; in_last = 1'b0; in_vert = '0;
    tri_q = {32'h000A_000A, 32'h0014_000A, 32'h000F_0014};

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    n_rst = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    mode = 0; send_poly("tri_pass", tri_q, 1'b0);
    mode = 1; send_poly("tri_killtop", tri_q, 1'b0);
    mode = 2; q = {32'h0001_0001, 32'h0009_0001, 32'h0009_0009, 32'h0001_0009};
    send_poly("quad_double", q, 1'b0);

    mode = 0; stall_req = 5; oready_mode = 1;
    send_poly("tri_stall", tri_q, 1'b0);
    chk("stall_consumed", stall_req, 0);
    oready_mode = 0;

    mode = 0; q = {32'h0003_0004, 32'h0005_0006};
    send_poly("two_vert", q, 1'b0);

    q = {};
    for (int i = 0; i < 10; i++) q.push_back(32'h0100_0000 + i);
    send_poly("load_ovf", q, 1'b0);

    // Reset while the LEFT pass waits for its clip result.
    mode = 0; lat_min = 6; lat_max = 6; saw_left = 1'b0;
    load_poly(tri_q, 1'b0);
    t = 0;
    while (!saw_left && t < 2000) begin @(negedge clk); t++; end
    chk("left_seen", saw_left, 1'b1);
    #2 n_rst = 1'b0;
    #1 check_reset_vals("midrst");
    exp_edges.delete(); exp_beats.delete();
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b1;
    lat_min = 0; lat_max = 2;
    @(negedge clk);
    q = {32'h0020_0020, 32'h0030_0020, 32'h0030_0030, 32'h0020_0030};
    send_poly("post_rst", q, 1'b0);

    eready_rand = 1; oready_mode = 2; lat_max = 3;
    for (int it = 0; it < 20; it++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 10)); i++) q.push_back($urandom);
      mode = $urandom_range(0, 3);
      send_poly("rand", q, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
